silife_grid_port_arbiter: RTL and testbench

Sequencer and arbiter for the grid's single row-write port (`row_select` / `set_cells` / `clear_cells`) and its generation-step `enable`. It replaces the fixed TRNG > SPI-loader > Wishbone priority mux with burst-locked round-robin arbitration between NREQ requesters. Generation steps are scheduled only between bursts, so a step never lands in the middle of a pattern load. It sits between the loaders and `silife_grid_32x32`.

---
 rtl/silife_pkg.sv | 24 ++
 rtl/silife_rr_picker.sv | 45 ++++
 rtl/silife_grid_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_silife_grid_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// ---------------------------------------------------------------------------
// silife_pkg
// Shared types and constants for the SiLife grid port arbiter.
//   silife_arb_state_t : arbiter FSM states (IDLE, GRANT, STEP)
//   SILIFE_REQ_*       : fixed requester slot indices on the arbiter ports
// ---------------------------------------------------------------------------
package silife_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      STEP  = 2'd2
   } silife_arb_state_t;

   localparam int SILIFE_REQ_TRNG = 0;
   localparam int SILIFE_REQ_SPI  = 1;
   localparam int SILIFE_REQ_WB   = 2;

   // Width of an index into NREQ requesters (at least 1 bit).
   function automatic int silife_idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/silife_rr_picker.sv
// ---------------------------------------------------------------------------
// silife_rr_picker
// Combinational round-robin picker. Searches from i_last+1 upward, wrapping
// at NREQ, and returns the first requester found as a one-hot vector.
//   i_req    : NREQ request lines
//   i_last   : index of the most recent winner
//   o_valid  : at least one request is present
//   o_winner : one-hot winner (all zero when o_valid is low)
// ---------------------------------------------------------------------------
module silife_rr_picker
   import silife_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int IDX_BITS = silife_idx_bits(NREQ)
) (
   input  logic [NREQ-1:0]     i_req,
   input  logic [IDX_BITS-1:0] i_last,
   output logic                o_valid,
   output logic [NREQ-1:0]     o_winner
);

   logic w_found;

   assign o_valid = |i_req;

   // Two passes instead of a modular index: first the slots above the last
   // winner, then the wrapped-around slots at or below it.
   always_comb begin
      o_winner = '0;
      w_found  = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!w_found && i_req[j] && (IDX_BITS'(j) > i_last)) begin
            o_winner[j] = 1'b1;
            w_found     = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!w_found && i_req[j] && !(IDX_BITS'(j) > i_last)) begin
            o_winner[j] = 1'b1;
            w_found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/silife_grid_port_arbiter.sv
// ---------------------------------------------------------------------------
// silife_grid_port_arbiter
// Burst-locked round-robin arbiter for the grid's single row-write port, plus
// the generation-step sequencer. Steps are only issued between bursts.
//   clk, reset              : clock, asynchronous active-low reset
//   i_req / i_last          : per-requester burst request / final-beat flag
//   i_row_select            : packed row per requester (ROW_BITS each)
//   i_set_cells/i_clear_cells : packed cell masks per requester (WIDTH each)
//   o_grant                 : registered one-hot grant
//   o_row_select, o_set_cells, o_clear_cells : muxed write port to the grid
//   i_step_req              : request one generation step
//   o_grid_enable           : one-cycle step pulse to the grid
//   o_step_pending          : step latched, not yet issued
//   o_busy                  : arbiter active or anything waiting
// ---------------------------------------------------------------------------
module silife_grid_port_arbiter
   import silife_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int HEIGHT    = 32,
   parameter int NREQ      = 3,
   parameter int MAX_BURST = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NREQ-1:0]              i_req,
   input  logic [NREQ-1:0]              i_last,
   input  logic [NREQ*$clog2(HEIGHT)-1:0] i_row_select,
   input  logic [NREQ*WIDTH-1:0]        i_set_cells,
   input  logic [NREQ*WIDTH-1:0]        i_clear_cells,
   output logic [NREQ-1:0]              o_grant,
   output logic [$clog2(HEIGHT)-1:0]    o_row_select,
   output logic [WIDTH-1:0]             o_set_cells,
   output logic [WIDTH-1:0]             o_clear_cells,
   input  logic                         i_step_req,
   output logic                         o_grid_enable,
   output logic                         o_step_pending,
   output logic                         o_busy
);

   localparam int ROW_BITS = $clog2(HEIGHT);
   localparam int IDX_BITS = silife_idx_bits(NREQ);
   localparam int CNT_BITS = $clog2(MAX_BURST + 1);

   silife_arb_state_t     r_state, w_state_nxt;
   logic [NREQ-1:0]       r_grant, w_grant_nxt;
   logic [IDX_BITS-1:0]   r_last, w_last_nxt;
   logic [CNT_BITS-1:0]   r_cnt, w_cnt_nxt;
   logic                  r_step_pending;
   logic [ROW_BITS-1:0]   r_row;

   logic                  w_pick_valid;
   logic [NREQ-1:0]       w_pick;
   logic [IDX_BITS-1:0]   w_pick_idx;
   logic                  w_beat, w_last_beat, w_enter_step;
   logic [ROW_BITS-1:0]   w_row_in;
   logic [WIDTH-1:0]      w_set_in, w_clr_in;

   silife_rr_picker #(.NREQ(NREQ), .IDX_BITS(IDX_BITS)) u_picker (
      .i_req    (i_req),
      .i_last   (r_last),
      .o_valid  (w_pick_valid),
      .o_winner (w_pick)
   );

   always_comb begin
      w_pick_idx = '0;
      for (int j = 0; j < NREQ; j++)
         if (w_pick[j]) w_pick_idx = IDX_BITS'(j);
   end

   // Beat detection and data mux. Only the granted requester can produce a
   // beat; everyone else is ignored until the arbiter is back in IDLE.
   always_comb begin
      w_beat      = 1'b0;
      w_last_beat = 1'b0;
      w_row_in    = '0;
      w_set_in    = '0;
      w_clr_in    = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (r_grant[j] && i_req[j]) begin
            w_beat      = 1'b1;
            w_last_beat = i_last[j];
            w_row_in    = i_row_select[j*ROW_BITS +: ROW_BITS];
            w_set_in    = i_set_cells[j*WIDTH +: WIDTH];
            w_clr_in    = i_clear_cells[j*WIDTH +: WIDTH];
         end
      end
   end

   assign w_enter_step = (r_state == IDLE) && r_step_pending;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (r_step_pending) begin
               w_state_nxt = STEP;
               w_grant_nxt = '0;
            end else if (w_pick_valid) begin
               w_state_nxt = GRANT;
               w_grant_nxt = w_pick;
               w_last_nxt  = w_pick_idx;
               w_cnt_nxt   = '0;
            end
         end
         GRANT: begin
            if (w_beat) begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_last_beat || (r_cnt == CNT_BITS'(MAX_BURST - 1))) begin
                  w_state_nxt = IDLE;
                  w_grant_nxt = '0;
               end
            end else begin
               // Requester dropped its request: burst is over, no beat.
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
            end
         end
         STEP: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_grant        <= '0;
         r_last         <= IDX_BITS'(NREQ - 1);
         r_cnt          <= '0;
         r_step_pending <= 1'b0;
         r_row          <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_grant        <= w_grant_nxt;
         r_last         <= w_last_nxt;
         r_cnt          <= w_cnt_nxt;
         // A new request in the cycle the step is taken starts a fresh one.
         r_step_pending <= i_step_req | (r_step_pending & ~w_enter_step);
         if (w_beat) r_row <= w_row_in;
      end
   end

   assign o_grant        = r_grant;
   assign o_row_select   = w_beat ? w_row_in : r_row;
   assign o_set_cells    = w_beat ? w_set_in : '0;
   assign o_clear_cells  = w_beat ? w_clr_in : '0;
   assign o_grid_enable  = (r_state == STEP);
   assign o_step_pending = r_step_pending;
   assign o_busy         = (r_state != IDLE) | (|i_req) | r_step_pending;

endmodule

// File: tb/tb_silife_grid_port_arbiter.sv
module tb_silife_grid_port_arbiter;

   localparam int WIDTH     = 32;
   localparam int HEIGHT    = 32;
   localparam int NREQ      = 3;
   localparam int MAX_BURST = 32;
   localparam int RB        = 5;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NREQ-1:0]         i_req, i_last;
   logic [NREQ*RB-1:0]      i_row_select;
   logic [NREQ*WIDTH-1:0]   i_set_cells, i_clear_cells;
   logic                    i_step_req;
   logic [NREQ-1:0]         o_grant;
   logic [RB-1:0]           o_row_select;
   logic [WIDTH-1:0]        o_set_cells, o_clear_cells;
   logic                    o_grid_enable, o_step_pending, o_busy;

   int checks = 0;
   int errors = 0;

   silife_grid_port_arbiter #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NREQ(NREQ), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req          (i_req),
      .i_last         (i_last),
      .i_row_select   (i_row_select),
      .i_set_cells    (i_set_cells),
      .i_clear_cells  (i_clear_cells),
      .o_grant        (o_grant),
      .o_row_select   (o_row_select),
      .o_set_cells    (o_set_cells),
      .o_clear_cells  (o_clear_cells),
      .i_step_req     (i_step_req),
      .o_grid_enable  (o_grid_enable),
      .o_step_pending (o_step_pending),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 = waiting between bursts, 1 = burst owned by m_k, 2 = step cycle
   int            m_mode    = 0;
   int            m_k       = 0;
   int            m_last    = NREQ - 1;
   int            m_beats   = 0;
   bit            m_pending = 1'b0;
   logic [RB-1:0] m_row     = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_mode = 0; m_k = 0; m_last = NREQ - 1; m_beats = 0;
         m_pending = 1'b0; m_row = '0;
      end else begin : upd
         bit beat, np;
         int win;
         beat = (m_mode == 1) && i_req[m_k];
         if (beat) m_row = i_row_select[m_k*RB +: RB];
         np = i_step_req || (m_pending && m_mode != 0);
         if (m_mode == 0) begin
            win = -1;
            for (int i = 1; i <= NREQ; i++)
               if (win < 0 && i_req[(m_last + i) % NREQ]) win = (m_last + i) % NREQ;
            if (m_pending) m_mode = 2;
            else if (win >= 0) begin
               m_mode = 1; m_k = win; m_last = win; m_beats = 0;
            end
         end else if (m_mode == 1) begin
            if (!beat) m_mode = 0;
            else begin
               m_beats++;
               if (i_last[m_k] || m_beats == MAX_BURST) m_mode = 0;
            end
         end else begin
            m_mode = 0;
         end
         m_pending = np;
      end
   end

   // Compare process: outputs against the model every cycle out of reset.
   always @(negedge clk) begin
      if (reset === 1'b1) begin : cmp
         bit beat;
         logic [NREQ-1:0]  eg;
         logic [RB-1:0]    er;
         logic [WIDTH-1:0] es, ec;
         beat = (m_mode == 1) && i_req[m_k];
         eg = (m_mode == 1) ? NREQ'(1 << m_k) : '0;
         er = beat ? i_row_select[m_k*RB +: RB] : m_row;
         es = beat ? i_set_cells[m_k*WIDTH +: WIDTH] : '0;
         ec = beat ? i_clear_cells[m_k*WIDTH +: WIDTH] : '0;
         chk("grant", 64'(o_grant), 64'(eg));
         chk("row", 64'(o_row_select), 64'(er));
         chk("set", 64'(o_set_cells), 64'(es));
         chk("clear", 64'(o_clear_cells), 64'(ec));
         chk("enable", 64'(o_grid_enable), 64'(m_mode == 2));
         chk("pending", 64'(o_step_pending), 64'(m_pending));
         chk("busy", 64'(o_busy), 64'((m_mode != 0) || (|i_req) || m_pending));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic neg();
      @(negedge clk); #1;
   endtask

   task automatic rand_data();
      logic [31:0] t;
      t = $urandom();
      i_row_select  = t[NREQ*RB-1:0];
      i_set_cells   = {$urandom(), $urandom(), $urandom()};
      i_clear_cells = {$urandom(), $urandom(), $urandom()};
   endtask

   logic [NREQ-1:0] rr_exp [8];
   int              pulses;

   initial begin
      rr_exp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
      reset = 1'b0; i_req = '0; i_last = '0; i_step_req = 1'b0;
      i_row_select = '0; i_set_cells = '0; i_clear_cells = '0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;

      // Reset values
      neg();
      chk("rst_grant", 64'(o_grant), 64'h0);
      chk("rst_enable", 64'(o_grid_enable), 64'h0);
      chk("rst_pending", 64'(o_step_pending), 64'h0);
      chk("rst_row", 64'(o_row_select), 64'h0);
      chk("rst_busy", 64'(o_busy), 64'h0);

      // Reset priority: 1 and 2 together -> 1 first, idle gap, then 2
      cyc(); rand_data(); i_req = 3'b110;
      cyc(); i_last = 3'b010;
      neg(); chk("prio_first", 64'(o_grant), 64'h2);
      cyc(); i_req = 3'b100; i_last = '0;
      neg(); chk("prio_gap", 64'(o_grant), 64'h0);
      cyc();
      neg(); chk("prio_second", 64'(o_grant), 64'h4);
      cyc(); i_req = '0;
      cyc(); cyc();

      // Round-robin with single-beat bursts
      i_req = 3'b111; i_last = 3'b111;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i == 7) begin i_req = '0; i_last = '0; end
         neg(); chk("rr_seq", 64'(o_grant), 64'(rr_exp[i]));
      end
      cyc();

      // Step deferred behind a 32-beat SPI burst
      rand_data(); i_req = 3'b010;
      for (int b = 1; b <= 32; b++) begin
         cyc();
         i_row_select[RB +: RB] = RB'(b - 1);
         i_last     = (b == 32) ? 3'b010 : 3'b000;
         i_step_req = (b == 3);
         neg();
         chk("defer_grant", 64'(o_grant), 64'h2);
         chk("defer_noenable", 64'(o_grid_enable), 64'h0);
         if (b == 10) chk("defer_pending", 64'(o_step_pending), 64'h1);
      end
      cyc(); i_req = '0; i_last = '0; i_step_req = 1'b0;
      neg(); chk("defer_idle_en", 64'(o_grid_enable), 64'h0);
      chk("defer_idle_gnt", 64'(o_grant), 64'h0);
      cyc();
      neg(); chk("defer_step_en", 64'(o_grid_enable), 64'h1);
      chk("defer_step_gnt", 64'(o_grant), 64'h0);
      cyc();
      neg(); chk("defer_after_en", 64'(o_grid_enable), 64'h0);
      chk("defer_after_pend", 64'(o_step_pending), 64'h0);

      // Step merge: three pulses during one burst give one step
      rand_data(); i_req = 3'b001;
      for (int b = 1; b <= 10; b++) begin
         cyc();
         i_last     = (b == 10) ? 3'b001 : 3'b000;
         i_step_req = (b == 2 || b == 4 || b == 6);
         if (b == 4) begin
            neg(); chk("merge_pending", 64'(o_step_pending), 64'h1);
         end
      end
      cyc(); i_req = '0; i_last = '0; i_step_req = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         neg(); if (o_grid_enable) pulses++;
         cyc();
      end
      chk("merge_pulses", 64'(pulses), 64'd1);

      // MAX_BURST forced release, re-grant to the other waiter
      rand_data(); i_req = 3'b001;
      cyc(); i_req = 3'b101;
      neg(); chk("max_grant", 64'(o_grant), 64'h1);
      for (int b = 2; b <= 32; b++) begin
         cyc();
         neg(); chk("max_grant", 64'(o_grant), 64'h1);
      end
      cyc();
      neg(); chk("max_release", 64'(o_grant), 64'h0);
      cyc(); i_req = '0;
      neg(); chk("max_regrant", 64'(o_grant), 64'h4);
      cyc(); cyc();

      // Async reset mid-burst
      rand_data(); i_set_cells[WIDTH-1:0] = 32'hA5A5_0001; i_clear_cells[WIDTH-1:0] = 32'h0F0F_0002;
      i_req = 3'b001;
      cyc(); cyc();
      #2 reset = 1'b0;
      #1;
      chk("arst_grant", 64'(o_grant), 64'h0);
      chk("arst_set", 64'(o_set_cells), 64'h0);
      chk("arst_clear", 64'(o_clear_cells), 64'h0);
      @(negedge clk); #2 reset = 1'b1; i_req = 3'b111;
      cyc();
      neg(); chk("arst_first", 64'(o_grant), 64'h1);
      cyc(); i_req = '0;
      cyc(); cyc();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cyc();
         for (int k = 0; k < NREQ; k++) begin
            if (i_req[k]) begin
               if ($urandom_range(9) == 0) i_req[k] = 1'b0;
            end else if ($urandom_range(3) == 0) i_req[k] = 1'b1;
            i_last[k] = ($urandom_range(5) == 0);
         end
         i_step_req = ($urandom_range(9) == 0);
         rand_data();
      end
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
